// File: rtl/project_id_pkg.sv
// Shared types and defaults for the project-ID ROM and its GPIO-default serialiser.
package project_id_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } pid_state_e;

  localparam int DEF_NUM_WORDS = 4;
  localparam int DEF_WORD_W    = 13;
  localparam int DEF_CLK_DIV   = 2;

  function automatic int proj_id_bits(input int nw, input int ww);
    return nw * ww;
  endfunction

endpackage

// File: rtl/project_id_phase_timer.sv
// Loadable down-counter giving a one-cycle tick in the last cycle of a CLK_DIV-long phase.
module project_id_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  output logic tick
);

  localparam int              PW    = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0]   DIV_L = PW'(CLK_DIV);
  localparam logic [PW-1:0]   ONE   = PW'(1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= DIV_L;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign tick = (cnt == ONE);

endmodule

// File: rtl/project_id_rom_serial.sv
// Project-ID ROM with GPIO default words shifted out on a divided serial chain.
// Optional build macro PROJECT_ID_AUTOLOAD_EN: start one transfer automatically after reset.
module project_id_rom_serial
  import project_id_pkg::*;
#(
  parameter logic [31:0] USER_PROJECT_ID = 32'h0,
  parameter int          NUM_WORDS       = DEF_NUM_WORDS,
  parameter int          WORD_W          = DEF_WORD_W,
  parameter logic [proj_id_bits(NUM_WORDS, WORD_W)-1:0] ROM_INIT = '0,
  parameter int          CLK_DIV         = DEF_CLK_DIV,
  localparam int         AW              = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clock,
  input  logic              resetn,
  output logic [31:0]       project_id,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data,
  input  logic              xfer_start,
  output logic              xfer_busy,
  output logic              xfer_done,
  output logic              serial_clock,
  output logic              serial_data,
  output logic              serial_load
);

  localparam int             NBITS     = proj_id_bits(NUM_WORDS, WORD_W);
  localparam int             BCW       = $clog2(NBITS + 1);
  localparam int             ROM_PAD_W = 2 ** BCW;
  localparam int             RD_DEPTH  = 2 ** AW;
  localparam logic [BCW-1:0] NBITS_L   = BCW'(NBITS);
  localparam logic [BCW-1:0] BC_ONE    = BCW'(1);
  // Padding lets any bit-counter value index the ROM without a range check.
  localparam logic [ROM_PAD_W-1:0] ROM_PAD = ROM_PAD_W'(ROM_INIT);

  pid_state_e     state, state_n;
  logic [BCW-1:0] bitcnt, bitcnt_n, bit_idx;
  logic           start_req, phase_load, phase_tick, data_n;
  logic [WORD_W-1:0] words [RD_DEPTH];

  assign project_id = USER_PROJECT_ID;

  genvar g;
  for (g = 0; g < RD_DEPTH; g++) begin : g_word
    if (g < NUM_WORDS) begin : g_used
      assign words[g] = ROM_INIT[g*WORD_W +: WORD_W];
    end else begin : g_empty
      assign words[g] = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rd_data <= '0;
    else         rd_data <= words[rd_addr];
  end

`ifdef PROJECT_ID_AUTOLOAD_EN
  logic autoload_done;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) autoload_done <= 1'b0;
    else         autoload_done <= 1'b1;
  end

  assign start_req = xfer_start | ~autoload_done;
`else
  assign start_req = xfer_start;
`endif

  project_id_phase_timer #(.CLK_DIV(CLK_DIV)) u_phase (
    .clock  (clock),
    .resetn (resetn),
    .load   (phase_load),
    .tick   (phase_tick)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      bitcnt <= '0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    case (state)
      IDLE: begin
        if (start_req) begin
          state_n  = SHIFT_LO;
          bitcnt_n = NBITS_L;
        end
      end
      SHIFT_LO: if (phase_tick) state_n = SHIFT_HI;
      SHIFT_HI: begin
        if (phase_tick) begin
          bitcnt_n = bitcnt - BC_ONE;
          state_n  = (bitcnt == BC_ONE) ? LOAD : SHIFT_LO;
        end
      end
      LOAD:    if (phase_tick) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Every state entry restarts the phase timer.
    phase_load = (state_n != state);
    // Bit n-1 of the packed ROM is the MSB of the top word, so it goes first.
    bit_idx = bitcnt_n - BC_ONE;
    data_n  = 1'b0;
    if (state_n == SHIFT_LO)      data_n = ROM_PAD[bit_idx];
    else if (state_n == SHIFT_HI) data_n = serial_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      xfer_busy    <= 1'b0;
      xfer_done    <= 1'b0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
    end else begin
      xfer_busy    <= (state_n != IDLE);
      xfer_done    <= (state_n == DONE);
      serial_clock <= (state_n == SHIFT_HI);
      serial_data  <= data_n;
      serial_load  <= (state_n == LOAD);
    end
  end

endmodule

// File: tb/tb_project_id_rom_serial.sv
// Self-checking bench: three ROM/serialiser instances against a behavioural model.
module tb_project_id_rom_serial;

  logic        clock = 1'b0;
  logic        resetn;
  logic [2:0]  start;
  wire  [2:0]  busy, done, sclk, sdat, sload;
  logic [0:0]  rd_addr0, rd_addr1;
  logic [1:0]  rd_addr2;
  wire  [3:0]  rd_data0, rd_data1;
  wire  [4:0]  rd_data2;
  wire  [31:0] pid0, pid1, pid2;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  project_id_rom_serial #(.USER_PROJECT_ID(32'hDEADBEEF), .NUM_WORDS(2), .WORD_W(4),
    .ROM_INIT(8'hA5), .CLK_DIV(1)) u0 (
    .clock(clock), .resetn(resetn), .project_id(pid0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .xfer_start(start[0]), .xfer_busy(busy[0]), .xfer_done(done[0]),
    .serial_clock(sclk[0]), .serial_data(sdat[0]), .serial_load(sload[0]));

  project_id_rom_serial #(.USER_PROJECT_ID(32'hDEADBEEF), .NUM_WORDS(2), .WORD_W(4),
    .ROM_INIT(8'hA5), .CLK_DIV(3)) u1 (
    .clock(clock), .resetn(resetn), .project_id(pid1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .xfer_start(start[1]), .xfer_busy(busy[1]), .xfer_done(done[1]),
    .serial_clock(sclk[1]), .serial_data(sdat[1]), .serial_load(sload[1]));

  project_id_rom_serial #(.USER_PROJECT_ID(32'h12345678), .NUM_WORDS(3), .WORD_W(5),
    .ROM_INIT(15'h5A3C), .CLK_DIV(2)) u2 (
    .clock(clock), .resetn(resetn), .project_id(pid2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .xfer_start(start[2]), .xfer_busy(busy[2]), .xfer_done(done[2]),
    .serial_clock(sclk[2]), .serial_data(sdat[2]), .serial_load(sload[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cd_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 2;
  endfunction
  function automatic int nw_of(input int d);
    return (d == 2) ? 3 : 2;
  endfunction
  function automatic int ww_of(input int d);
    return (d == 2) ? 5 : 4;
  endfunction
  function automatic logic [63:0] rom_of(input int d);
    return (d == 2) ? 64'h5A3C : 64'hA5;
  endfunction

  function automatic logic [63:0] model_word(input logic [63:0] rom, input int nw, input int ww,
                                             input int a);
    if (a >= nw) return 64'd0;
    return (rom >> (a * ww)) & ((64'd1 << ww) - 64'd1);
  endfunction

  // Expected chain order: highest word first, each word MSB first.
  task automatic model_bits(input logic [63:0] rom, input int nw, input int ww, output bit q[$]);
    logic [63:0] w;
    q = {};
    for (int wi = nw - 1; wi >= 0; wi--) begin
      w = model_word(rom, nw, ww, wi);
      for (int b = ww - 1; b >= 0; b--) q.push_back(w[b]);
    end
  endtask

  task automatic readback(input int d, input int a);
    logic [63:0] obs;
    @(negedge clock);
    case (d)
      0: rd_addr0 = a[0:0];
      1: rd_addr1 = a[0:0];
      default: rd_addr2 = a[1:0];
    endcase
    @(negedge clock);
    case (d)
      0: obs = 64'(rd_data0);
      1: obs = 64'(rd_data1);
      default: obs = 64'(rd_data2);
    endcase
    chk($sformatf("readback d%0d a%0d", d, a), obs, model_word(rom_of(d), nw_of(d), ww_of(d), a));
  endtask

  task automatic assert_reset();
    @(negedge clock);
    resetn = 1'b0;
    start  = '0;
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_sclk", 64'(sclk), 0);
    chk("rst_sdat", 64'(sdat), 0);
    chk("rst_sload", 64'(sload), 0);
    chk("rst_rd_data", {rd_data0, rd_data1, rd_data2}, 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic release_reset();
    int seen;
    @(negedge clock);
    resetn = 1'b1;
`ifdef PROJECT_ID_AUTOLOAD_EN
    @(negedge clock);
    chk("autoload_busy", 64'(busy), 64'h7);
    for (int c = 0; c < 300 && busy != 3'b000; c++) @(negedge clock);
    chk("autoload_end", 64'(busy), 0);
`endif
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (busy != 3'b000) seen++;
    end
    chk("no_auto_retransfer", seen, 0);
  endtask

  task automatic run_xfer(input int d, input bit hold);
    bit          exp_q[$];
    logic [63:0] exp_v, got_v;
    int          cd, nw, ww, got_n, busy_len, done_n, done_at, load_n;
    int          bad_hi, bad_lo, bad_dat, hi_run, lo_run;
    bit          prev_sclk, prev_dat, rise_dat, finished;
    cd = cd_of(d); nw = nw_of(d); ww = ww_of(d);
    model_bits(rom_of(d), nw, ww, exp_q);
    exp_v = '0;
    foreach (exp_q[i]) exp_v = {exp_v[62:0], exp_q[i]};
    got_v = '0; got_n = 0; busy_len = 0; done_n = 0; done_at = -1; load_n = 0;
    bad_hi = 0; bad_lo = 0; bad_dat = 0; hi_run = 0; lo_run = 0;
    prev_sclk = 1'b0; prev_dat = 1'b0; rise_dat = 1'b0; finished = 1'b0;
    @(negedge clock);
    start[d] = 1'b1;
    for (int c = 0; c < 400 && !finished; c++) begin
      @(negedge clock);
      if (!hold) start[d] = 1'b0;
      if (c == 0) begin
        chk($sformatf("d%0d first_busy", d), 64'(busy[d]), 1);
        chk($sformatf("d%0d first_bit", d), 64'(sdat[d]), 64'(exp_q[0]));
      end
      if (done[d]) begin
        done_n++;
        done_at = busy_len + 1;
      end
      if (!busy[d]) begin
        finished = 1'b1;
      end else begin
        busy_len++;
        if (sload[d]) load_n++;
        if (sclk[d]) begin
          if (!prev_sclk) begin
            got_v = {got_v[62:0], sdat[d]};
            got_n++;
            if (lo_run != cd) bad_lo++;
            hi_run   = 0;
            rise_dat = sdat[d];
          end
          hi_run++;
          if (sdat[d] !== rise_dat || sload[d]) bad_dat++;
        end else begin
          if (prev_sclk) begin
            if (hi_run != cd) bad_hi++;
            lo_run = 0;
          end
          lo_run++;
          if (lo_run > 1 && !sload[d] && !done[d] && sdat[d] !== prev_dat) bad_dat++;
          if ((sload[d] || done[d]) && sdat[d] !== 1'b0) bad_dat++;
        end
        prev_sclk = sclk[d];
        prev_dat  = sdat[d];
      end
    end
    chk($sformatf("d%0d finished", d), 64'(finished), 1);
    chk($sformatf("d%0d busy_len", d), busy_len, 2 * cd * nw * ww + cd + 1);
    chk($sformatf("d%0d bit_count", d), got_n, nw * ww);
    chk($sformatf("d%0d bits", d), got_v, exp_v);
    chk($sformatf("d%0d done_count", d), done_n, 1);
    chk($sformatf("d%0d done_last_busy", d), done_at, busy_len);
    chk($sformatf("d%0d load_cycles", d), load_n, cd);
    chk($sformatf("d%0d hi_phase_len", d), bad_hi, 0);
    chk($sformatf("d%0d lo_phase_len", d), bad_lo, 0);
    chk($sformatf("d%0d data_stable", d), bad_dat, 0);
  endtask

  initial begin
    int d, a, len, dn, rises, done_seen;
    bit prev;
    resetn = 1'b0;
    start = '0;
    rd_addr0 = '0; rd_addr1 = '0; rd_addr2 = '0;

    assert_reset();
    release_reset();

    chk("project_id0", 64'(pid0), 64'hDEADBEEF);
    chk("project_id2", 64'(pid2), 64'h12345678);

    readback(0, 1);
    chk("readback_A", 64'(rd_data0), 64'hA);
    readback(0, 0);
    chk("readback_5", 64'(rd_data0), 64'h5);
    readback(2, 3);
    for (int i = 0; i < 12; i++) begin
      d = $urandom_range(0, 2);
      a = (d == 2) ? $urandom_range(0, 3) : $urandom_range(0, 1);
      readback(d, a);
    end

    run_xfer(0, 1'b0);
    repeat ($urandom_range(0, 3)) @(negedge clock);
    run_xfer(1, 1'b0);
    run_xfer(2, 1'b0);

    // Start held high: exactly one transfer, then a restart from the following IDLE cycle.
    run_xfer(0, 1'b1);
    @(negedge clock);
    chk("hold_restart", 64'(busy[0]), 1);
    start[0] = 1'b0;
    len = 1; dn = 0;
    for (int c = 0; c < 100 && busy[0]; c++) begin
      @(negedge clock);
      if (busy[0]) len++;
      if (done[0]) dn++;
    end
    chk("hold_second_len", len, 18);
    chk("hold_second_done", dn, 1);

    // Reset asserted partway through the shift.
    rises = 0; done_seen = 0; prev = 1'b0;
    @(negedge clock);
    start[0] = 1'b1;
    for (int c = 0; c < 100 && rises < 3; c++) begin
      @(negedge clock);
      start[0] = 1'b0;
      if (done[0]) done_seen++;
      if (sclk[0] && !prev) rises++;
      prev = sclk[0];
    end
    chk("mid_rises", rises, 3);
    chk("mid_busy", 64'(busy[0]), 1);
    assert_reset();
    chk("mid_no_done", done_seen, 0);
    release_reset();
    run_xfer(0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      d = $urandom_range(0, 2);
      repeat ($urandom_range(0, 4)) @(negedge clock);
      run_xfer(d, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
